// File: rtl/noise_sched_pkg.sv
// Shared types and widths for the noise lane scheduler.
package noise_sched_pkg;

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int unsigned DROP_CNT_W = 16;
  // Holds warm-up counts up to 255.
  localparam int unsigned WARM_CNT_W = 8;

endpackage

// File: rtl/noise_lane_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the stored
// pointer, and a pointer register that moves past the winner on advance.
//   clk, rst  : clock, synchronous active-high reset (pointer -> lane 0)
//   req       : per-lane request vector
//   advance   : accept the current grant and rotate the pointer
//   grant_c   : combinational one-hot grant (all-zero when req is zero)
module rr_arbiter #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 advance,
  output logic [NUM_LANES-1:0] grant_c
);

  localparam int unsigned PTR_W = $clog2(NUM_LANES);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // Scan lanes from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_c   = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = ptr_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_c[idx]   = 1'b1;
        grant_idx      = idx;
      end
      idx = (idx == PTR_W'(NUM_LANES - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

  // Next pointer is one past the winner, modulo NUM_LANES.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/noise_lane_scheduler.sv
// Shares one Gaussian noise stream between NUM_LANES lanes: warms up the
// generator, then hands each valid sample to one requester round-robin and
// counts samples nobody wanted.
//   clk, rst    : clock, synchronous active-high reset
//   start, stop : sequencing pulses (stop wins when both are high)
//   gen_en      : generator enable (registered)
//   gen_sample, gen_valid : generator stream
//   lane_req    : per-lane level requests
//   lane_sample, lane_valid : registered sample and one-hot grant
//   ready       : high while in RUN
//   drop_count  : saturating count of unrequested RUN samples
module noise_lane_scheduler
  import noise_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned SIGNAL_RESOLUTION = 9,
  parameter int unsigned WARMUP_SAMPLES    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stop,
  output logic                                gen_en,
  input  logic signed [SIGNAL_RESOLUTION-1:0] gen_sample,
  input  logic                                gen_valid,
  input  logic        [NUM_LANES-1:0]         lane_req,
  output logic signed [SIGNAL_RESOLUTION-1:0] lane_sample,
  output logic        [NUM_LANES-1:0]         lane_valid,
  output logic                                ready,
  output logic        [DROP_CNT_W-1:0]        drop_count
);

  typedef logic signed [SIGNAL_RESOLUTION-1:0] sample_t;

  state_t                  state_q, state_d;
  logic [WARM_CNT_W-1:0]   warm_q, warm_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic [NUM_LANES-1:0]    valid_q, valid_d;
  sample_t                 sample_q, sample_d;
  logic                    gen_en_q, ready_q;
  logic [NUM_LANES-1:0]    grant_c;
  logic                    advance_c;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (lane_req),
    .advance (advance_c),
    .grant_c (grant_c)
  );

  // Next-state, warm-up counting, grant capture and drop counting.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    drop_d    = drop_q;
    valid_d   = '0;
    sample_d  = sample_q;
    advance_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = WARMUP;
          warm_d  = '0;
        end
      end
      WARMUP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (gen_valid) begin
          warm_d = warm_q + WARM_CNT_W'(1);
          if (warm_q == WARM_CNT_W'(WARMUP_SAMPLES - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (gen_valid) begin
          if (|lane_req) begin
            valid_d   = grant_c;
            sample_d  = gen_sample;
            advance_c = 1'b1;
          end else if (drop_q != {DROP_CNT_W{1'b1}}) begin
            drop_d = drop_q + DROP_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      warm_q   <= '0;
      drop_q   <= '0;
      valid_q  <= '0;
      sample_q <= '0;
      gen_en_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      gen_en_q <= (state_d != IDLE);
      ready_q  <= (state_d == RUN);
    end
  end

  assign gen_en      = gen_en_q;
  assign ready       = ready_q;
  assign lane_valid  = valid_q;
  assign lane_sample = sample_q;
  assign drop_count  = drop_q;

endmodule
